// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from a synchronous ROM and splits the IR into fields.
// Defining FETCH_RETIRE_CNT_EN adds the o_retire_cnt retired-instruction counter.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          IMEM_AW     = 8,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_rd_en,
    output logic [IMEM_AW-1:0] o_imem_addr,
    input  logic [31:0]        i_imem_rdata,
    input  logic [31:0]        i_pc_resolved,
    input  logic               i_stall,
    output logic [5:0]         o_opcode,
    output logic [4:0]         o_rs_addr,
    output logic [4:0]         o_rt_addr,
    output logic [4:0]         o_rd_addr,
    output logic [15:0]        o_immediate_1,
    output logic [25:0]        o_immediate_2,
    output logic [31:0]        o_pc_plus4,
    output logic               o_instr_valid,
    output logic               o_halted
`ifdef FETCH_RETIRE_CNT_EN
    ,output logic [31:0]       o_retire_cnt
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXECUTE, S_HALTED} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir;
    logic        w_unused;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = S_FETCH;
            S_FETCH:   w_next = S_WAIT;
            S_WAIT:    w_next = S_DECODE;
            S_DECODE:  w_next = (i_imem_rdata[31:26] == HALT_OPCODE) ? S_HALTED : S_EXECUTE;
            S_EXECUTE: w_next = i_stall ? S_EXECUTE : S_FETCH;
            default:   w_next = r_state;
        endcase
    end

    always_comb begin
        o_imem_rd_en  = (r_state == S_FETCH);
        o_instr_valid = (r_state == S_EXECUTE);
        o_halted      = (r_state == S_HALTED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= PC_RESET;
            r_ir <= '0;
        end else begin
            if (r_state == S_DECODE) r_ir <= i_imem_rdata;
            if (r_state == S_EXECUTE && !i_stall) r_pc <= {i_pc_resolved[31:2], 2'b00};
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_retire_cnt <= '0;
        else if (r_state == S_EXECUTE && !i_stall) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
    assign o_retire_cnt = r_retire_cnt;
`endif

    // Bits above the ROM address range are ignored, so fetches wrap within the ROM.
    assign o_imem_addr   = r_pc[IMEM_AW+1:2];
    assign o_pc_plus4    = r_pc + 32'd4;
    assign o_opcode      = r_ir[31:26];
    assign o_rs_addr     = r_ir[25:21];
    assign o_rt_addr     = r_ir[20:16];
    assign o_rd_addr     = r_ir[15:11];
    assign o_immediate_1 = r_ir[15:0];
    assign o_immediate_2 = r_ir[25:0];
    assign w_unused      = ^i_pc_resolved[1:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + randomized instruction stream against a transaction-level model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [7:0]  addr;
    logic [31:0] rdata = '0;
    logic [31:0] pres;
    logic        stall;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm1;
    logic [25:0] imm2;
    logic [31:0] pc4;
    logic        valid, halted;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] cnt;
`endif

    logic [31:0] rom [256];
    logic [31:0] m_pc, m_ir, m_cnt;
    int          total = 0, bad = 0, cyc = 0, exec_cyc = 0;
    bit          hit;

    instr_fetch_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_imem_rd_en(rd_en), .o_imem_addr(addr),
        .i_imem_rdata(rdata), .i_pc_resolved(pres), .i_stall(stall),
        .o_opcode(opcode), .o_rs_addr(rs), .o_rt_addr(rt), .o_rd_addr(rd),
        .o_immediate_1(imm1), .o_immediate_2(imm2), .o_pc_plus4(pc4),
        .o_instr_valid(valid), .o_halted(halted)
`ifdef FETCH_RETIRE_CNT_EN
        , .o_retire_cnt(cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rd_en) rdata <= rom[addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input logic e_rd, input logic e_valid, input logic e_halt, input string tag);
        chk({tag, ".rd_en"}, rd_en, e_rd);
        chk({tag, ".addr"}, addr, (m_pc >> 2) % 256);
        chk({tag, ".opcode"}, opcode, m_ir >> 26);
        chk({tag, ".rs"}, rs, (m_ir >> 21) & 31);
        chk({tag, ".rt"}, rt, (m_ir >> 16) & 31);
        chk({tag, ".rd"}, rd, (m_ir >> 11) & 31);
        chk({tag, ".imm1"}, imm1, m_ir & 32'hFFFF);
        chk({tag, ".imm2"}, imm2, m_ir & 32'h03FF_FFFF);
        chk({tag, ".pc4"}, pc4, m_pc + 32'd4);
        chk({tag, ".valid"}, valid, e_valid);
        chk({tag, ".halted"}, halted, e_halt);
`ifdef FETCH_RETIRE_CNT_EN
        chk({tag, ".cnt"}, cnt, m_cnt);
`endif
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous assertion mid-cycle; returns observing the first FETCH cycle.
    task automatic do_reset;
        #3;
        rst_n = 1'b0;
        stall = 1'b0;
        #1;
        m_pc = 32'h0; m_ir = 32'h0; m_cnt = 32'h0;
        chk_out(0, 0, 0, "rst");
        step;
        step;
        rst_n = 1'b1;
        cyc = 1;
        chk_out(0, 0, 0, "idle");
        step;
    endtask

    // Entered and left while observing a FETCH cycle (or HALTED when hit=1).
    task automatic do_instr(input int ns, input logic [31:0] p, output bit h);
        h = 1'b0;
        chk_out(1, 0, 0, "fetch");
        step;
        chk_out(0, 0, 0, "wait");
        step;
        chk_out(0, 0, 0, "decode");
        step;
        m_ir = rom[(m_pc >> 2) % 256];
        if (m_ir[31:26] == 6'h3F) begin
            chk_out(0, 0, 1, "halt");
            h = 1'b1;
        end else begin
            exec_cyc = cyc;
            chk_out(0, 1, 0, "exec");
            pres = p;
            stall = (ns > 0);
            for (int i = 0; i < ns; i++) begin
                if (i == ns - 1) begin
                    step;
                    stall = 1'b0;
                end else step;
                chk_out(0, 1, 0, "stall");
            end
            step;
            m_pc = p & 32'hFFFF_FFFC;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] p;
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
            if (rom[i][31:26] == 6'h3F) rom[i][31:26] = 6'h00;
        end
        rom[0] = 32'h2022_0005;
        rom[2] = 32'hFC00_0000;
        stall = 1'b0;
        pres = '0;
        rst_n = 1'b0;
        #1;
        do_reset;
        chk("t1.fetch_cyc", cyc, 2);
        do_instr(0, 32'h4, hit);
        chk("t1.exec_cyc", exec_cyc, 5);
        chk("t2.opcode", opcode, 6'h08);
        chk("t2.rs", rs, 5'd1);
        chk("t2.rt", rt, 5'd2);
        chk("t2.imm1", imm1, 16'h0005);
        chk("t2.addr", addr, 8'h01);
        do_instr(0, 32'h41, hit);
        chk("t3.addr", addr, 8'h10);
        do_instr(3, 32'h44, hit);
        for (int n = 0; n < 12; n++) begin
            p = ($urandom_range(0, 1) == 1) ? m_pc + 32'd4 : $urandom;
            while (((p >> 2) % 256) == 2) p = $urandom;
            do_instr($urandom_range(0, 2), p, hit);
        end
        do_instr(0, 32'h8, hit);
        do_instr(0, 32'h0, hit);
        chk("t5.hit", hit, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step;
            chk_out(0, 0, 1, "halted");
        end
        do_reset;
        do_instr(0, 32'hFFFF_FFFF, hit);
        chk("t6.pc4_wrap", pc4, 32'h0);
        chk("t6.addr_wrap", addr, 8'hFF);
        step;
        chk_out(0, 0, 0, "t6.wait");
        do_reset;
        chk("t6.restart_addr", addr, 8'h00);
        do_instr(0, 32'h4, hit);
        chk("t6.ir_after", opcode, 6'h08);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
